net_fifo_buf_v2: RTL and testbench

Parametrised synchronous FIFO for PHY-side buffering of 64b data words with a sideband control/sync-header field (CWIDTH bits, e.g. 2'b10 data / 2'b01 ctrl).
- Show-ahead head word; exact occupancy and free-space counts.
- Programmable almost-full/almost-empty watermarks for upstream backpressure and downstream scheduling.
- Sticky overflow/underflow error flags, peak-occupancy monitor, and synchronous flush.
- Sits between the PCS/encoder stage and the network scheduler.

---
 rtl/net_fifo_buf_v2_if.sv | 37 +++
 rtl/net_fifo_buf_v2.sv | 119 +++++++++++
 tb/tb_net_fifo_buf_v2.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/net_fifo_buf_v2_if.sv
// Bus bundle for net_fifo_buf_v2: write/read handshakes, control inputs
// and the status/occupancy outputs presented back to the producer side.
interface net_fifo_buf_v2_if #(
    parameter int DWIDTH = 64,
    parameter int CWIDTH = 2,
    parameter int DEPTH  = 3
);
    logic              flush;
    logic              err_clr;
    logic              wr;
    logic [DWIDTH-1:0] w_data_d;
    logic [CWIDTH-1:0] w_data_c;
    logic              rd;
    logic [DWIDTH-1:0] r_data_d;
    logic [CWIDTH-1:0] r_data_c;
    logic              empty;
    logic              full;
    logic              almost_full;
    logic              almost_empty;
    logic [DEPTH:0]    count;
    logic [DEPTH:0]    space;
    logic [DEPTH:0]    peak;
    logic              overflow;
    logic              underflow;

    modport master (
        output flush, err_clr, wr, w_data_d, w_data_c, rd,
        input  r_data_d, r_data_c, empty, full, almost_full,
        input  almost_empty, count, space, peak, overflow, underflow
    );

    modport slave (
        input  flush, err_clr, wr, w_data_d, w_data_c, rd,
        output r_data_d, r_data_c, empty, full, almost_full,
        output almost_empty, count, space, peak, overflow, underflow
    );
endinterface

// File: rtl/net_fifo_buf_v2.sv
// Show-ahead FIFO for 64b PHY words plus sync-header sideband, with
// watermarks, sticky error flags, peak monitor and synchronous flush.
module net_fifo_buf_v2 #(
    parameter int DWIDTH    = 64,
    parameter int CWIDTH    = 2,
    parameter int DEPTH     = 3,
    parameter int AF_THRESH = 6,
    parameter int AE_THRESH = 2
) (
    input  logic           clk,
    input  logic           reset,
    net_fifo_buf_v2_if.slave io_bus
);
    localparam int N = 1 << DEPTH;
    localparam logic [DEPTH:0] W_N  = (DEPTH+1)'(N);
    localparam logic [DEPTH:0] W_AF = (DEPTH+1)'(AF_THRESH);
    localparam logic [DEPTH:0] W_AE = (DEPTH+1)'(AE_THRESH);

    logic [DWIDTH-1:0] r_mem_d [N];
    logic [CWIDTH-1:0] r_mem_c [N];

    logic [DEPTH-1:0] r_wptr;
    logic [DEPTH-1:0] r_rptr;
    logic [DEPTH:0]   r_count;
    logic [DEPTH:0]   r_space;
    logic [DEPTH:0]   r_peak;
    logic             r_empty;
    logic             r_full;
    logic             r_af;
    logic             r_ae;
    logic             r_ovf;
    logic             r_udf;

    logic             w_rd_acc;
    logic             w_wr_acc;
    logic             w_ovf_ev;
    logic             w_udf_ev;
    logic [DEPTH:0]   w_cnt_nxt;
    logic [DEPTH:0]   w_peak_nxt;

    // Flush swallows both requests, so nothing is accepted or flagged.
    assign w_rd_acc = ~io_bus.flush & io_bus.rd & ~r_empty;
    assign w_wr_acc = ~io_bus.flush & io_bus.wr & (~r_full | io_bus.rd);
    assign w_ovf_ev = ~io_bus.flush & io_bus.wr & r_full & ~io_bus.rd;
    assign w_udf_ev = ~io_bus.flush & io_bus.rd & r_empty;

    always_comb begin
        w_cnt_nxt = r_count;
        if (io_bus.flush) begin
            w_cnt_nxt = '0;
        end else begin
            w_cnt_nxt = r_count
                      + {{DEPTH{1'b0}}, w_wr_acc}
                      - {{DEPTH{1'b0}}, w_rd_acc};
        end
    end

    always_comb begin
        w_peak_nxt = r_peak;
        if (io_bus.err_clr) begin
            w_peak_nxt = w_cnt_nxt;
        end else if (w_cnt_nxt > r_peak) begin
            w_peak_nxt = w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_space <= W_N;
            r_peak  <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
            r_af    <= 1'b0;
            r_ae    <= 1'b1;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            if (io_bus.flush) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_wr_acc) r_wptr <= r_wptr + 1'b1;
                if (w_rd_acc) r_rptr <= r_rptr + 1'b1;
            end
            // Flags derive from the next count so they never lag it.
            r_count <= w_cnt_nxt;
            r_space <= W_N - w_cnt_nxt;
            r_empty <= (w_cnt_nxt == '0);
            r_full  <= (w_cnt_nxt == W_N);
            r_af    <= (w_cnt_nxt >= W_AF);
            r_ae    <= (w_cnt_nxt <= W_AE);
            r_peak  <= w_peak_nxt;
            r_ovf   <= w_ovf_ev | (r_ovf & ~io_bus.err_clr);
            r_udf   <= w_udf_ev | (r_udf & ~io_bus.err_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem_d[r_wptr] <= io_bus.w_data_d;
            r_mem_c[r_wptr] <= io_bus.w_data_c;
        end
    end

    assign io_bus.r_data_d     = r_mem_d[r_rptr];
    assign io_bus.r_data_c     = r_mem_c[r_rptr];
    assign io_bus.empty        = r_empty;
    assign io_bus.full         = r_full;
    assign io_bus.almost_full  = r_af;
    assign io_bus.almost_empty = r_ae;
    assign io_bus.count        = r_count;
    assign io_bus.space        = r_space;
    assign io_bus.peak         = r_peak;
    assign io_bus.overflow     = r_ovf;
    assign io_bus.underflow    = r_udf;
endmodule

// File: tb/tb_net_fifo_buf_v2.sv
// Bench for net_fifo_buf_v2: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_net_fifo_buf_v2;
    localparam int DW = 64;
    localparam int CW = 2;
    localparam int DP = 3;
    localparam int AF = 6;
    localparam int AE = 2;
    localparam int N  = 8;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } ent_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    net_fifo_buf_v2_if #(.DWIDTH(DW), .CWIDTH(CW), .DEPTH(DP)) bus ();

    net_fifo_buf_v2 #(
        .DWIDTH(DW), .CWIDTH(CW), .DEPTH(DP),
        .AF_THRESH(AF), .AE_THRESH(AE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .io_bus(bus.slave)
    );

    int   n_chk  = 0;
    int   n_fail = 0;
    ent_t q[$];
    bit   m_ovf;
    bit   m_udf;
    int   m_peak;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
        m_peak = 0;
    endtask

    task automatic model(input bit wr, input bit rd, input bit fl,
                         input bit clr, input ent_t e);
        bit ov;
        bit ud;
        ov = 1'b0;
        ud = 1'b0;
        if (fl) begin
            q.delete();
        end else begin
            int  sz;
            bit  rok;
            bit  wok;
            sz  = q.size();
            rok = rd && sz > 0;
            wok = wr && (sz < N || rd);
            ov  = wr && !wok;
            ud  = rd && sz == 0;
            if (rok) void'(q.pop_front());
            if (wok) q.push_back(e);
        end
        m_ovf = ov | (m_ovf & !clr);
        m_udf = ud | (m_udf & !clr);
        if (clr || q.size() > m_peak) m_peak = q.size();
    endtask

    task automatic compare();
        int sz;
        sz = q.size();
        chk("empty", bus.empty, sz == 0);
        chk("full", bus.full, sz == N);
        chk("almost_full", bus.almost_full, sz >= AF);
        chk("almost_empty", bus.almost_empty, sz <= AE);
        chk("count", bus.count, sz);
        chk("space", bus.space, N - sz);
        chk("peak", bus.peak, m_peak);
        chk("overflow", bus.overflow, m_ovf);
        chk("underflow", bus.underflow, m_udf);
        if (sz > 0) begin
            chk("r_data_d", bus.r_data_d, q[0].d);
            chk("r_data_c", bus.r_data_c, q[0].c);
        end
    endtask

    task automatic step(input bit wr, input bit rd, input bit fl,
                        input bit clr, input logic [DW-1:0] d,
                        input logic [CW-1:0] c);
        ent_t e;
        e.d = d;
        e.c = c;
        bus.wr       = wr;
        bus.rd       = rd;
        bus.flush    = fl;
        bus.err_clr  = clr;
        bus.w_data_d = d;
        bus.w_data_c = c;
        model(wr, rd, fl, clr, e);
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic clear_errs();
        step(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_empty"}, bus.empty, 1);
        chk({tag, "_full"}, bus.full, 0);
        chk({tag, "_ae"}, bus.almost_empty, 1);
        chk({tag, "_af"}, bus.almost_full, 0);
        chk({tag, "_count"}, bus.count, 0);
        chk({tag, "_space"}, bus.space, 8);
        chk({tag, "_peak"}, bus.peak, 0);
        chk({tag, "_ovf"}, bus.overflow, 0);
        chk({tag, "_udf"}, bus.underflow, 0);
    endtask

    initial begin
        int wbias;
        int rbias;
        reset        = 1'b1;
        bus.wr       = 1'b0;
        bus.rd       = 1'b0;
        bus.flush    = 1'b0;
        bus.err_clr  = 1'b0;
        bus.w_data_d = '0;
        bus.w_data_c = '0;
        model_reset();
        #12;
        chk_reset_vals("t1");
        @(negedge clk);
        reset = 1'b0;
        compare();

        // Fill with 0x01..0x08, watch watermarks rise.
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, DW'(i), 2'b10);
            if (i == 2) chk("t2_ae_at2", bus.almost_empty, 1);
            if (i == 3) chk("t2_ae_at3", bus.almost_empty, 0);
            if (i == 5) chk("t2_af_at5", bus.almost_full, 0);
            if (i == 6) chk("t2_af_at6", bus.almost_full, 1);
        end
        chk("t2_full", bus.full, 1);
        chk("t2_count8", bus.count, 8);
        chk("t2_space0", bus.space, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 64'h99, 2'b10);
        chk("t2_ovf", bus.overflow, 1);
        chk("t2_count_hold", bus.count, 8);
        for (int i = 1; i <= 8; i++) begin
            chk("t2_rd_data", bus.r_data_d, i);
            step(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
        end
        chk("t2_empty", bus.empty, 1);

        // Full plus simultaneous write/read.
        clear_errs();
        for (int i = 0; i < 8; i++)
            step(1'b1, 1'b0, 1'b0, 1'b0, DW'(32'h10 + i), 2'b10);
        step(1'b1, 1'b1, 1'b0, 1'b0, 64'hAA, 2'b01);
        chk("t3_count", bus.count, 8);
        chk("t3_full", bus.full, 1);
        chk("t3_ovf", bus.overflow, 0);
        for (int i = 0; i < 7; i++)
            step(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
        chk("t3_head_d", bus.r_data_d, 64'hAA);
        chk("t3_head_c", bus.r_data_c, 2'b01);
        step(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);

        // Empty plus simultaneous write/read.
        step(1'b1, 1'b1, 1'b0, 1'b0, 64'h55, 2'b10);
        chk("t4_count", bus.count, 1);
        chk("t4_empty", bus.empty, 0);
        chk("t4_udf", bus.underflow, 1);
        chk("t4_data", bus.r_data_d, 64'h55);
        clear_errs();
        chk("t4_udf_clr", bus.underflow, 0);
        chk("t4_peak", bus.peak, 1);
        step(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);

        // Random traffic with shifting bias to exercise bursts and wrap.
        wbias = 50;
        rbias = 50;
        for (int i = 0; i < 600; i++) begin
            if (i % 25 == 0) begin
                wbias = $urandom_range(10, 95);
                rbias = $urandom_range(10, 95);
            end
            step($urandom_range(0, 99) < wbias,
                 $urandom_range(0, 99) < rbias,
                 $urandom_range(0, 99) < 2,
                 $urandom_range(0, 99) < 3,
                 {$urandom, $urandom},
                 CW'($urandom));
        end

        // Flush at count 5 with a write pending.
        step(1'b1, 1'b0, 1'b1, 1'b1, '0, '0);
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b0, 1'b0, 1'b0, {$urandom, $urandom}, 2'b10);
        chk("t6_count5", bus.count, 5);
        step(1'b1, 1'b0, 1'b1, 1'b0, 64'h77, 2'b10);
        chk("t6_count0", bus.count, 0);
        chk("t6_empty", bus.empty, 1);
        chk("t6_space", bus.space, 8);
        chk("t6_ovf", bus.overflow, 0);
        chk("t6_peak", bus.peak, 5);

        // Async reset in the middle of a burst.
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 1'b0, 1'b0, DW'(32'h200 + i), 2'b10);
        bus.wr = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk_reset_vals("t6r");
        model_reset();
        @(negedge clk);
        reset  = 1'b0;
        bus.wr = 1'b0;
        compare();
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 1'b0, 1'b0, DW'(32'h300 + i), 2'b01);
        chk("t6r_first", bus.r_data_d, 64'h300);
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
